// File: rtl/module_mult_control.sv
// module_mult_control: sequential radix-2 Booth multiplier with control FSM; optional zero-operand early exit via MULT_EARLY_EXIT_EN
module module_mult_control #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     numero1_i,
    input  logic [WIDTH-1:0]     numero2_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic                 start_dly_q, start_dly_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 start_rise;
    logic                 skip;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;

    assign start_rise = start & ~start_dly_q;
    assign sum  = ({q_q[0], qm1_q} == 2'b01) ? a_q + m_q :
                  ({q_q[0], qm1_q} == 2'b10) ? a_q - m_q : a_q;
    assign a_sh = {sum[WIDTH], sum[WIDTH:1]};
    assign q_sh = {sum[0], q_q[WIDTH-1:1]};
`ifdef MULT_EARLY_EXIT_EN
    assign skip = (numero1_i == '0) || (numero2_i == '0);
`else
    assign skip = 1'b0;
`endif
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign product_o = product_q;

    // Next-state and datapath: load on accepted edge, one Booth step per CALC cycle
    always_comb begin
        state_d     = state_q;
        start_dly_d = start;
        m_d         = m_q;
        a_d         = a_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        if (state_q == IDLE && start_rise) begin
            m_d       = {numero1_i[WIDTH-1], numero1_i};
            a_d       = '0;
            q_d       = numero2_i;
            qm1_d     = 1'b0;
            cnt_d     = '0;
            product_d = skip ? '0 : product_q;
            state_d   = skip ? DONE : CALC;
        end else if (state_q == CALC) begin
            a_d   = a_sh;
            q_d   = q_sh;
            qm1_d = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                product_d = {a_sh[WIDTH-1:0], q_sh};
                state_d   = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers, cleared asynchronously by active-low rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_dly_q <= 1'b0;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start_dly_d;
            m_q         <= m_d;
            a_q         <= a_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
        end
    end
endmodule

// File: tb/tb_module_mult_control.sv
// tb_module_mult_control: directed checks of the Booth multiplier against hand-computed products
module tb_module_mult_control;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  numero1_i = '0;
    logic [7:0]  numero2_i = '0;
    logic        busy;
    logic        done;
    logic [15:0] product_o;
    int          total = 0;
    int          bad = 0;

    module_mult_control #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .numero1_i(numero1_i), .numero2_i(numero2_i),
        .busy(busy), .done(done), .product_o(product_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int lat);
        int k;
        numero1_i = a;
        numero2_i = b;
        start = 1'b1;
        tick();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(lat));
        check({tag, "_prod"}, 32'(product_o), 32'(exp));
        start = 1'b0;
        tick();
        check({tag, "_done_w"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    initial begin
        int p;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product_o), 32'd0);
        rst = 1'b1;
        tick();

        run("m7x-3", 8'h07, 8'hFD, 16'hFFEB, 8);
        run("m99x99", 8'h63, 8'h63, 16'h2649, 8);
        run("m-99x99", 8'h9D, 8'h63, 16'hD9B7, 8);
        run("m-128x-128", 8'h80, 8'h80, 16'h4000, 8);
        run("m-128x1", 8'h80, 8'h01, 16'hFF80, 8);

        numero1_i = 8'h05;
        numero2_i = 8'h06;
        start = 1'b1;
        count_done(30, p);
        check("held_pulses", 32'(p), 32'd1);
        check("held_prod", 32'(product_o), 32'h001E);
        start = 1'b0;
        tick();

        numero1_i = 8'h03;
        numero2_i = 8'h04;
        start = 1'b1;
        p = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) p++;
            if (i == 3) begin
                start = 1'b0;
                numero1_i = 8'h02;
                numero2_i = 8'h02;
            end
            if (i == 4) start = 1'b1;
        end
        check("retrig_pulses", 32'(p), 32'd1);
        check("retrig_prod", 32'(product_o), 32'h000C);
        start = 1'b0;
        tick();

        numero1_i = 8'h07;
        numero2_i = 8'hFD;
        start = 1'b1;
        tick();
        repeat (4) tick();
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_prod", 32'(product_o), 32'd0);
        tick();
        rst = 1'b1;
        count_done(10, p);
        check("abort_nopulse", 32'(p), 32'd0);
        run("m12x11", 8'h0C, 8'h0B, 16'h0084, 8);

`ifdef MULT_EARLY_EXIT_EN
        run("m0x55", 8'h00, 8'h37, 16'h0000, 0);
`else
        run("m0x55", 8'h00, 8'h37, 16'h0000, 8);
`endif
        run("m-1x-1", 8'hFF, 8'hFF, 16'h0001, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/module_mult_control.md
Name: module_mult_control

Overview:
Sequential radix-2 Booth multiplier with its controlling FSM. It consumes the two signed two's-complement operands and the level-type valid produced by the data-capture subsystem. It runs one Booth iteration per clock and returns a signed double-width product with a one-cycle done pulse. It sits between the capture subsystem and the display/result stage of the multiplier design.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  operand-valid level from capture stage; only its rising edge is acted on
numero1_i  input  WIDTH  multiplicand, signed two's complement
numero2_i  input  WIDTH  multiplier, signed two's complement
busy  output  1  high whenever FSM not in IDLE
done  output  1  one-cycle pulse, product_o valid
product_o  output  2*WIDTH  signed product, held until next completion

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, product_o=0, start edge-detect register=0, iteration counter=0, all datapath registers=0.
- Edge detect: start_d <= start every cycle; start_rise = start & ~start_d. A start held high produces exactly one operation.
- Datapath registers: M (WIDTH+1 bits, sign-extended numero1_i), A accumulator (WIDTH+1 bits), Q (WIDTH bits), q_m1 (1 bit), counter (clog2(WIDTH)+1 bits).
- FSM states: IDLE, CALC, DONE.
- IDLE: if start_rise, load M=sext(numero1_i), A=0, Q=numero2_i, q_m1=0, counter=0; go to CALC. Otherwise stay in IDLE.
- CALC, one iteration per cycle:
  - {Q[0],q_m1} = 01: A+M.
  - {Q[0],q_m1} = 10: A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,q_m1} by one, with A MSB replicated.
  - counter++.
  - On the iteration where counter reaches WIDTH-1, i.e. the WIDTH-th iteration: product_o <= low 2*WIDTH bits of the shifted {A,Q}; go to DONE.
- DONE: done=1 for this single cycle; unconditionally go to IDLE.
- Latency: capture edge e0. Iterations occur on e1..eWIDTH. done is high in the cycle following eWIDTH, i.e. WIDTH cycles after e0 (8 for default).
- Throughput: a new start_rise is accepted no earlier than the cycle after DONE.
- Arithmetic: the WIDTH+1-bit accumulator makes the full signed range exact, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2), with no overflow.
- busy = (state != IDLE), registered-equivalent (derived from state register only).
- start_rise while in CALC or DONE: ignored, not queued. start_d still tracks start, so a level held through completion does not retrigger.
- numero1_i/numero2_i changing during CALC: no effect; operands are sampled only at the accepting edge.
- Reset mid-operation: aborts immediately to IDLE. product_o clears to 0 and done is not pulsed.
- Product register is not cleared at new start; it changes only at CALC->DONE or reset.

Optional Feature:
Macro MULT_EARLY_EXIT_EN.
- Defined: in IDLE on start_rise, if numero1_i==0 or numero2_i==0, skip CALC. product_o <= 0 at the accepting edge and go straight to DONE, so done is high one cycle after e0. Non-zero operands behave as normal.
- Not defined: every operation takes exactly WIDTH iterations regardless of operand values.

Test Plan:
- 7 x -3 (numero1_i=8'h07, numero2_i=8'hFD), start 0->1 -> busy=1 next cycle; done pulses 8 cycles after the capture edge; product_o=16'hFFEB (-21); busy=0 after done.
- 99 x 99 then -99 x 99 back-to-back -> product_o=16'h2649 (9801), then 16'hD9B7 (-9801); each done exactly one cycle wide.
- -128 x -128 (8'h80, 8'h80) -> product_o=16'h4000; -128 x 1 -> 16'hFF80.
- start held high for 30 cycles, then a second 0->1 edge at cycle 4 of CALC -> only one done pulse; the edge during busy is ignored; product is from the first operands.
- rst asserted low during the 5th CALC cycle -> busy, done, product_o all 0 immediately (async); no done pulse; a later start_rise runs a full 8-cycle operation correctly.
- 0 x 55 -> with MULT_EARLY_EXIT_EN, done 1 cycle after the edge with product_o=0; without the macro, done after 8 cycles with product_o=0.
